// File: rtl/vga_mux_pkg.sv
// Shared constants for the VGA source mux: FSM state encoding, the sel encoding
// and the default colour width.
package vga_mux_pkg;

  localparam int CW_DEFAULT = 4;

  localparam logic [3:0] SEL_BLANK = 4'd0;

  typedef logic [1:0] state_t;

  localparam state_t ST_BLANK = 2'd0;
  localparam state_t ST_SHOW  = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;

endpackage

// File: rtl/vga_frame_blink.sv
// Frame-edge detector on the selected source's vsync, plus the frame counter that
// produces the blink phase. A clear from the mux restarts everything on a switch.
module vga_frame_blink #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic vsync_in,
  output logic frame_edge,
  output logic blink_phase
);

  localparam logic [7:0] FCNT_LAST = 8'(BLINK_FRAMES - 1);

  logic       vs_q, vs_d;
  logic       armed_q, armed_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic       phase_q, phase_d;

  // The registered vsync still belongs to the old source right after a switch,
  // so detection is held off for one cycle to avoid a spurious edge.
  always_comb begin
    frame_edge = armed_q & vs_q & ~vsync_in;
    vs_d       = vsync_in;
    armed_d    = ~clear;
    fcnt_d     = fcnt_q;
    phase_d    = phase_q;
    if (clear) begin
      fcnt_d  = '0;
      phase_d = 1'b0;
    end else if (frame_edge) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      vs_q    <= 1'b1;
      armed_q <= 1'b0;
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      vs_q    <= vs_d;
      armed_q <= armed_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_phase = phase_q;

endmodule

// File: rtl/vga_src_mux.sv
// VGA source selector: switches between NSRC sources only on a frame boundary
// (or after a timeout), with per-source blinking and a single registered output mux.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_BLANK | no source selected, outputs held at 0, cur_sel = 0
//   ST_SHOW  | steady on cur_sel
//   ST_WAIT  | switch to target requested, old source still shown
module vga_src_mux
  import vga_mux_pkg::*;
#(
  parameter int NSRC         = 4,
  parameter int CW           = CW_DEFAULT,
  parameter int BLINK_FRAMES = 30,
  parameter int SW_TIMEOUT   = 1000000
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NSRC*CW-1:0] src_r,
  input  logic [NSRC*CW-1:0] src_g,
  input  logic [NSRC*CW-1:0] src_b,
  input  logic [NSRC-1:0]    src_hsync,
  input  logic [NSRC-1:0]    src_vsync,
  input  logic [3:0]         sel,
  input  logic [NSRC-1:0]    blink_en,
  output logic               hsync,
  output logic               vsync,
  output logic [CW-1:0]      r,
  output logic [CW-1:0]      g,
  output logic [CW-1:0]      b,
  output logic [3:0]         cur_sel,
  output logic               pending
);

  localparam int            WCW       = $clog2(SW_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(SW_TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [3:0]     cur_sel_q, cur_sel_d;
  logic [3:0]     target_q, target_d;
  logic           pending_q, pending_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic [CW-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;

  logic [3:0]    nsel;
  logic          switch_now;
  logic          frame_edge;
  logic          blink_phase;
  logic          mux_hs, mux_vs, mux_blink;
  logic [CW-1:0] mux_r, mux_g, mux_b;

  always_comb begin
    mux_hs    = 1'b0;
    mux_vs    = 1'b1;
    mux_blink = 1'b0;
    mux_r     = '0;
    mux_g     = '0;
    mux_b     = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (cur_sel_q == 4'(k + 1)) begin
        mux_hs    = src_hsync[k];
        mux_vs    = src_vsync[k];
        mux_blink = blink_en[k];
        mux_r     = src_r[k*CW +: CW];
        mux_g     = src_g[k*CW +: CW];
        mux_b     = src_b[k*CW +: CW];
      end
    end
  end

  always_comb begin
    nsel       = (sel <= 4'(NSRC)) ? sel : SEL_BLANK;
    state_d    = state_q;
    cur_sel_d  = cur_sel_q;
    target_d   = target_q;
    pending_d  = pending_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_BLANK: begin
        if (nsel != SEL_BLANK) begin
          cur_sel_d = nsel;
          state_d   = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (nsel != cur_sel_q) begin
          target_d   = nsel;
          pending_d  = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A frame edge wins over a simultaneous sel change; the new sel is seen next cycle.
        if (frame_edge || (wait_cnt_q == WAIT_LAST)) begin
          cur_sel_d = target_q;
          pending_d = 1'b0;
          state_d   = (target_q == SEL_BLANK) ? ST_BLANK : ST_SHOW;
        end else if (nsel == cur_sel_q) begin
          pending_d = 1'b0;
          state_d   = ST_SHOW;
        end else begin
          target_d = nsel;
          if (wait_cnt_q < WAIT_LAST) wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_BLANK;
        cur_sel_d = SEL_BLANK;
        pending_d = 1'b0;
      end
    endcase
    switch_now = (cur_sel_d != cur_sel_q);
    if (switch_now) wait_cnt_d = '0;
  end

  always_comb begin
    hsync_d = 1'b0;
    vsync_d = 1'b0;
    r_d     = '0;
    g_d     = '0;
    b_d     = '0;
    if (state_q != ST_BLANK) begin
      hsync_d = mux_hs;
      vsync_d = mux_vs;
      if (!(mux_blink && blink_phase)) begin
        r_d = mux_r;
        g_d = mux_g;
        b_d = mux_b;
      end
    end
  end

  vga_frame_blink #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_frame_blink (
    .clk        (clk),
    .clr        (clr),
    .clear      (switch_now),
    .vsync_in   (mux_vs),
    .frame_edge (frame_edge),
    .blink_phase(blink_phase)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= ST_BLANK;
      cur_sel_q  <= SEL_BLANK;
      target_q   <= SEL_BLANK;
      pending_q  <= 1'b0;
      wait_cnt_q <= '0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
    end else begin
      state_q    <= state_d;
      cur_sel_q  <= cur_sel_d;
      target_q   <= target_d;
      pending_q  <= pending_d;
      wait_cnt_q <= wait_cnt_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
    end
  end

  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign r       = r_q;
  assign g       = g_q;
  assign b       = b_q;
  assign cur_sel = cur_sel_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_vga_src_mux.sv
// Directed bench for vga_src_mux with a short switch timeout and a two-frame blink.
module tb_vga_src_mux;

  localparam int NSRC = 4;
  localparam int CW   = 4;

  logic               clk = 1'b0;
  logic               clr;
  logic [NSRC*CW-1:0] src_r, src_g, src_b;
  logic [NSRC-1:0]    src_hsync, src_vsync;
  logic [3:0]         sel;
  logic [NSRC-1:0]    blink_en;
  logic               hsync, vsync;
  logic [CW-1:0]      r, g, b;
  logic [3:0]         cur_sel;
  logic               pending;
  logic [13:0]        obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign obs = {hsync, vsync, r, g, b};

  vga_src_mux #(
    .NSRC(NSRC), .CW(CW), .BLINK_FRAMES(2), .SW_TIMEOUT(16)
  ) dut (
    .clk(clk), .clr(clr),
    .src_r(src_r), .src_g(src_g), .src_b(src_b),
    .src_hsync(src_hsync), .src_vsync(src_vsync),
    .sel(sel), .blink_en(blink_en),
    .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b),
    .cur_sel(cur_sel), .pending(pending)
  );

  function automatic logic [13:0] src_out(input int k);
    return {src_hsync[k], src_vsync[k], src_r[k*CW +: CW], src_g[k*CW +: CW], src_b[k*CW +: CW]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_src();
    for (int k = 0; k < NSRC; k++) begin
      src_r[k*CW +: CW] = 4'(k + 1);
      src_g[k*CW +: CW] = 4'(k + 6);
      src_b[k*CW +: CW] = 4'(k + 11);
    end
    src_hsync = '0;
    src_vsync = '1;
  endtask

  task automatic do_reset();
    clr      = 1'b0;
    sel      = 4'd0;
    blink_en = '0;
    load_src();
    step();
    step();
    clr = 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b1; sel = 4'd3; blink_en = '0;
    load_src();
    #3 clr = 1'b0;
    #1;
    checks++;
    if (obs !== 14'd0) begin errors++; $display("FAIL reset_outputs got %h want %h", obs, 14'd0); end
    checks++;
    if (cur_sel !== 4'd0) begin errors++; $display("FAIL reset_cur_sel got %0d want 0", cur_sel); end
    step();
    step();
    checks++;
    if (pending !== 1'b0 || cur_sel !== 4'd0) begin
      errors++; $display("FAIL reset_held got pending=%b cur_sel=%0d want 0 0", pending, cur_sel);
    end
    clr = 1'b1;
  endtask

  task automatic test_select_from_blank();
    do_reset();
    src_hsync[1] = 1'b1;
    sel = 4'd2;
    step();
    checks++;
    if (cur_sel !== 4'd2 || pending !== 1'b0) begin
      errors++; $display("FAIL blank_to_show got cur_sel=%0d pending=%b want 2 0", cur_sel, pending);
    end
    step();
    checks++;
    if (obs !== src_out(1) || pending !== 1'b0) begin
      errors++; $display("FAIL blank_to_show_data got %h pending=%b want %h 0", obs, pending, src_out(1));
    end
  endtask

  task automatic test_switch_on_edge();
    do_reset();
    sel = 4'd1;
    step();
    step();
    checks++;
    if (obs !== src_out(0)) begin errors++; $display("FAIL edge_show_src0 got %h want %h", obs, src_out(0)); end
    sel = 4'd3;
    step();
    checks++;
    if (pending !== 1'b1 || cur_sel !== 4'd1) begin
      errors++; $display("FAIL edge_wait_entry got pending=%b cur_sel=%0d want 1 1", pending, cur_sel);
    end
    src_r[3:0] = 4'hA;
    step();
    checks++;
    if (obs !== src_out(0)) begin errors++; $display("FAIL edge_old_src_live got %h want %h", obs, src_out(0)); end
    src_vsync[0] = 1'b0;
    step();
    checks++;
    if (cur_sel !== 4'd3 || pending !== 1'b0) begin
      errors++; $display("FAIL edge_switch got cur_sel=%0d pending=%b want 3 0", cur_sel, pending);
    end
    checks++;
    if (obs !== src_out(0)) begin errors++; $display("FAIL edge_switch_cycle_data got %h want %h", obs, src_out(0)); end
    step();
    checks++;
    if (obs !== src_out(2)) begin errors++; $display("FAIL edge_new_src got %h want %h", obs, src_out(2)); end
  endtask

  task automatic test_cancel();
    do_reset();
    sel = 4'd1;
    step();
    step();
    sel = 4'd3;
    step();
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL cancel_wait got pending=%b want 1", pending); end
    sel = 4'd1;
    step();
    checks++;
    if (pending !== 1'b0 || cur_sel !== 4'd1 || obs !== src_out(0)) begin
      errors++; $display("FAIL cancel_drop got pending=%b cur_sel=%0d obs=%h want 0 1 %h", pending, cur_sel, obs, src_out(0));
    end
    src_vsync[0] = 1'b0;
    step();
    step();
    checks++;
    if (cur_sel !== 4'd1 || pending !== 1'b0) begin
      errors++; $display("FAIL cancel_no_switch got cur_sel=%0d pending=%b want 1 0", cur_sel, pending);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    sel = 4'd1;
    step();
    step();
    sel = 4'd2;
    step();
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (cur_sel !== 4'd1 || pending !== 1'b1) begin
      errors++; $display("FAIL timeout_15 got cur_sel=%0d pending=%b want 1 1", cur_sel, pending);
    end
    step();
    checks++;
    if (cur_sel !== 4'd2 || pending !== 1'b0) begin
      errors++; $display("FAIL timeout_16 got cur_sel=%0d pending=%b want 2 0", cur_sel, pending);
    end
  endtask

  task automatic test_retarget();
    do_reset();
    sel = 4'd1;
    step();
    step();
    sel = 4'd2;
    step();
    for (int i = 0; i < 5; i++) step();
    sel = 4'd3;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (cur_sel !== 4'd1 || pending !== 1'b1) begin
      errors++; $display("FAIL retarget_15 got cur_sel=%0d pending=%b want 1 1", cur_sel, pending);
    end
    step();
    checks++;
    if (cur_sel !== 4'd3 || pending !== 1'b0) begin
      errors++; $display("FAIL retarget_16 got cur_sel=%0d pending=%b want 3 0", cur_sel, pending);
    end
  endtask

  task automatic test_edge_and_sel();
    do_reset();
    sel = 4'd1;
    step();
    step();
    sel = 4'd3;
    step();
    sel = 4'd2;
    src_vsync[0] = 1'b0;
    step();
    checks++;
    if (cur_sel !== 4'd3 || pending !== 1'b0) begin
      errors++; $display("FAIL edge_sel_same got cur_sel=%0d pending=%b want 3 0", cur_sel, pending);
    end
    step();
    checks++;
    if (cur_sel !== 4'd3 || pending !== 1'b1) begin
      errors++; $display("FAIL edge_sel_next got cur_sel=%0d pending=%b want 3 1", cur_sel, pending);
    end
  endtask

  task automatic test_blink();
    logic [12:0] want;
    do_reset();
    blink_en = 4'b0001;
    sel = 4'd1;
    step();
    step();
    for (int n = 0; n < 6; n++) begin
      if (n > 0) begin
        src_vsync[0] = 1'b0;
        step();
        checks++;
        if (vsync !== 1'b0) begin errors++; $display("FAIL blink_vsync frame %0d got %b want 0", n, vsync); end
        src_vsync[0] = 1'b1;
      end
      step();
      step();
      src_hsync[0] = n[0];
      step();
      want = (n == 2 || n == 3) ? {n[0], 12'h000} : {n[0], 4'd1, 4'd6, 4'd11};
      checks++;
      if ({hsync, r, g, b} !== want) begin
        errors++; $display("FAIL blink_frame %0d got %h want %h", n, {hsync, r, g, b}, want);
      end
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    src_hsync = '1;
    sel = 4'd9;
    step();
    step();
    checks++;
    if (cur_sel !== 4'd0 || pending !== 1'b0 || obs !== 14'd0) begin
      errors++; $display("FAIL sel9_blank got cur_sel=%0d pending=%b obs=%h want 0 0 0", cur_sel, pending, obs);
    end
    sel = 4'd5;
    step();
    checks++;
    if (cur_sel !== 4'd0) begin errors++; $display("FAIL sel5_blank got %0d want 0", cur_sel); end
    sel = 4'd4;
    step();
    checks++;
    if (cur_sel !== 4'd4) begin errors++; $display("FAIL sel4_show got %0d want 4", cur_sel); end
    step();
    checks++;
    if (obs !== src_out(3)) begin errors++; $display("FAIL sel4_data got %h want %h", obs, src_out(3)); end
    sel = 4'd9;
    step();
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL sel9_wait got pending=%b want 1", pending); end
    src_vsync[3] = 1'b0;
    step();
    checks++;
    if (cur_sel !== 4'd0 || pending !== 1'b0) begin
      errors++; $display("FAIL sel9_switch got cur_sel=%0d pending=%b want 0 0", cur_sel, pending);
    end
    step();
    checks++;
    if (obs !== 14'd0) begin errors++; $display("FAIL sel9_outputs got %h want 0", obs); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    sel = 4'd1;
    step();
    step();
    sel = 4'd3;
    step();
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL midwait_pending got %b want 1", pending); end
    clr = 1'b0;
    #1;
    checks++;
    if (cur_sel !== 4'd0 || pending !== 1'b0 || obs !== 14'd0) begin
      errors++; $display("FAIL midwait_async got cur_sel=%0d pending=%b obs=%h want 0 0 0", cur_sel, pending, obs);
    end
    sel = 4'd0;
    step();
    clr = 1'b1;
    step();
    checks++;
    if (cur_sel !== 4'd0 || pending !== 1'b0) begin
      errors++; $display("FAIL midwait_after got cur_sel=%0d pending=%b want 0 0", cur_sel, pending);
    end
    sel = 4'd2;
    step();
    checks++;
    if (cur_sel !== 4'd2) begin errors++; $display("FAIL midwait_first_eval got %0d want 2", cur_sel); end
  endtask

  initial begin
    test_reset();
    test_select_from_blank();
    test_switch_on_edge();
    test_cancel();
    test_timeout();
    test_retarget();
    test_edge_and_sel();
    test_blink();
    test_out_of_range();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_src_mux.md
VGA_SRC_MUX -- requirements
Module: vga_src_mux

Interface
REQ-001 Parameter NSRC, default 4: number of video sources, range 1..15.
REQ-002 Parameter CW, default 4: colour bits per channel.
REQ-003 Parameter BLINK_FRAMES, default 30: source frames per blink half-period, range 1..255.
REQ-004 Parameter SW_TIMEOUT, default 1000000: clk cycles to wait for a frame edge before a switch is forced.
REQ-005 clk  in  1  pixel clock; all sequential logic on its rising edge.
REQ-006 clr  in  1  reset, asynchronous assert, active-low; synchronous deassert is outside this block.
REQ-007 src_r, src_g, src_b  in  NSRC*CW each  packed colour per source; source k occupies bits [k*CW +: CW], k = 0..NSRC-1.
REQ-008 src_hsync, src_vsync  in  NSRC each  per-source sync; vsync is active-low.
REQ-009 sel  in  4  requested source; 0 = blank, 1..NSRC = source sel-1, values above NSRC = blank.
REQ-010 blink_en  in  NSRC  per-source blink enable.
REQ-011 hsync, vsync  out  1  registered output sync.
REQ-012 r, g, b  out  CW each  registered output colour.
REQ-013 cur_sel  out  4  source currently driving the outputs, using the sel encoding.
REQ-014 pending  out  1  high while a requested switch is waiting for a frame boundary.

Function
REQ-015 FSM states: BLANK (cur_sel = 0), SHOW (steady), WAIT (switch requested).
REQ-016 Normalised request nsel = sel when sel <= NSRC; otherwise 0.
REQ-017 BLANK: outputs hsync = vsync = 0 and rgb = 0; when nsel != 0, load cur_sel = nsel on the next clk and go to SHOW, with no frame wait.
REQ-018 SHOW: when nsel != cur_sel, latch target = nsel, go to WAIT, assert pending.
REQ-019 Frame edge = falling edge of src_vsync[cur_sel-1], detected against a registered copy of that signal.
REQ-020 WAIT: on a frame edge, or when the wait counter reaches SW_TIMEOUT-1, set cur_sel = target and clear pending; next state is BLANK if target = 0, else SHOW.
REQ-021 WAIT: a sel change re-latches target without restarting the wait counter.
REQ-022 WAIT: nsel == cur_sel cancels the switch and returns to SHOW in the same cycle, clearing pending.
REQ-023 WAIT: the old source keeps driving the outputs until the switch cycle.
REQ-024 SHOW/WAIT data path: hsync, vsync and rgb are taken from source cur_sel-1 with exactly 1 clk latency; syncs and colour share that latency.
REQ-025 Blink: an 8-bit frame counter counts frame edges of the current source; on reaching BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase.
REQ-026 When blink_en[cur_sel-1] = 1 and blink_phase = 1, rgb outputs are 0 while syncs still pass through.
REQ-027 Every change of cur_sel clears the frame counter, blink_phase and the wait counter.
REQ-028 A frame edge and a sel change in the same cycle: the frame edge completes the pending switch to the old target; the new sel is evaluated the following cycle.
REQ-029 The wait counter saturates and does not wrap; a forced switch behaves identically to an edge-triggered switch.

Reset
REQ-030 clr low immediately forces state BLANK, cur_sel = 0, pending = 0, hsync = vsync = 0, r = g = b = 0, all counters 0, blink_phase = 0, regardless of operation in progress.
REQ-031 After clr rises, the first sel evaluation occurs on the first clk edge.

Structure
REQ-032 Shared package vga_mux_pkg holds the state enum, sel encoding constants (SEL_BLANK = 0) and the colour width default.
REQ-033 A single sub-module vga_frame_blink holds the vsync edge detector, frame counter and blink_phase, with a clear input driven on a switch.
REQ-034 No other hierarchy; the colour/sync select is one registered mux.

Verification
REQ-035 Reset, then sel = 2 from BLANK -> cur_sel = 2 one clk later; outputs equal source 1 rgb/sync one further clk later; pending never high.
REQ-036 SHOW source 1, sel -> 3 mid-frame -> pending = 1; outputs stay on source 0 until the src_vsync[0] fall; cur_sel = 3 on the next clk; pending = 0.
REQ-037 WAIT toward 3, sel returns to 1 before the vsync edge -> pending drops the next clk; cur_sel stays 1; no output glitch.
REQ-038 SW_TIMEOUT = 16, src_vsync of the current source held high, sel change -> switch occurs exactly 16 clks after WAIT entry.
REQ-039 BLINK_FRAMES = 2, blink_en[0] = 1, cur_sel = 1 -> rgb = 0 during frames 2-3, visible during 0-1 and 4-5; hsync/vsync toggle throughout.
REQ-040 sel = 9 with NSRC = 4, and clr pulsed low mid-WAIT -> each case gives BLANK outputs all 0; after reset, cur_sel = 0 and pending = 0.
